// File: rtl/status_tx_if.sv
// ---------------------------------------------------------------------------
// status_tx_if
// SPI pin bundle shared between the status transmitter and the host side.
//   i_sclk    : raw SPI clock (mode 0), driven by the host
//   i_cs_n    : raw chip select, active low, driven by the host
//   o_miso    : serial status data, MSB first, driven by the slave
//   o_misoOe  : MISO output enable, high while the slave is selected
// ---------------------------------------------------------------------------
interface status_tx_if;
   logic i_sclk;
   logic i_cs_n;
   logic o_miso;
   logic o_misoOe;

   modport slave (
      input  i_sclk,
      input  i_cs_n,
      output o_miso,
      output o_misoOe
   );

   modport master (
      output i_sclk,
      output i_cs_n,
      input  o_miso,
      input  o_misoOe
   );
endinterface

// File: rtl/status_tx.sv
// ---------------------------------------------------------------------------
// status_tx
// SPI-slave status frame transmitter. While the host clocks a command frame
// in, this block shifts a 64-bit status frame out on MISO, MSB first:
//   [63:56] flags  [55:52] seq  [51:40] vcIndex  [39:28] vcRepeat
//   [27:16] adc    [15:8] checksum  [7:0] MSG_TYPE
// Ports:
//   i_clk, i_rst_n     : system clock (>= 8x SCLK), async active-low reset
//   spi (slave)        : raw SCLK / CS_N in, MISO / MISO enable out
//   i_flags, i_vcIndex, i_vcRepeat, i_adc : live status, sampled at frame start
//   o_busy             : frame in progress (LOAD, SHIFT, DONE)
//   o_frameSent        : one-clock pulse after the 64th SCLK rising edge
//   o_seq              : sequence number that the next frame will carry
// ---------------------------------------------------------------------------
module status_tx #(
   parameter logic [7:0] MSG_TYPE    = 8'h81,
   parameter int         SYNC_STAGES = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   status_tx_if.slave   spi,
   input  logic [7:0]   i_flags,
   input  logic [11:0]  i_vcIndex,
   input  logic [11:0]  i_vcRepeat,
   input  logic [11:0]  i_adc,
   output logic         o_busy,
   output logic         o_frameSent,
   output logic [3:0]   o_seq
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE,
      ST_HOLD
   } state_t;

   // ---------------- synchronizers ----------------
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] w_sclk_d;
   logic [SYNC_STAGES-1:0] w_cs_d;
   logic                   r_sclk_prev;
   logic                   r_cs_prev;

   assign w_sclk_d[0] = spi.i_sclk;
   assign w_cs_d[0]   = spi.i_cs_n;

   genvar gi;
   generate
      for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync_chain
         assign w_sclk_d[gi] = r_sclk_sync[gi-1];
         assign w_cs_d[gi]   = r_cs_sync[gi-1];
      end
   endgenerate

   // CS chain resets to the deselected level so reset release is not seen
   // as a chip-select edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_sclk_prev <= 1'b0;
         r_cs_prev   <= 1'b1;
      end else begin
         r_sclk_sync <= w_sclk_d;
         r_cs_sync   <= w_cs_d;
         r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
         r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
      end
   end

   logic w_sclk_s;
   logic w_cs_s;
   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_cs_fall;
   logic w_cs_rise;

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk_rise =  w_sclk_s & ~r_sclk_prev;
   assign w_sclk_fall = ~w_sclk_s &  r_sclk_prev;
   assign w_cs_fall   = ~w_cs_s   &  r_cs_prev;
   assign w_cs_rise   =  w_cs_s   & ~r_cs_prev;

   // ---------------- frame assembly ----------------
   logic [3:0]  r_seq;
   logic [47:0] w_body;
   logic [7:0]  w_csum;
   logic [63:0] w_frame;

   assign w_body  = {i_flags, r_seq, i_vcIndex, i_vcRepeat, i_adc};
   assign w_csum  = w_body[47:40] ^ w_body[39:32] ^ w_body[31:24] ^
                    w_body[23:16] ^ w_body[15:8]  ^ w_body[7:0]   ^ MSG_TYPE;
   assign w_frame = {w_body, w_csum, MSG_TYPE};

   // ---------------- FSM ----------------
   state_t      r_state;
   state_t      w_state_next;
   logic [63:0] r_shreg;
   logic [6:0]  r_cnt;
   logic        r_miso;
   logic        w_busy;
   logic        w_oe;
   logic        w_sent;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      w_oe         = 1'b0;
      w_sent       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            // SCLK activity is irrelevant here; only a CS fall starts a frame,
            // which also makes CS win over a coincident SCLK edge.
            if (w_cs_fall) w_state_next = ST_LOAD;
         end
         ST_LOAD: begin
            w_busy = 1'b1;
            w_state_next = w_cs_rise ? ST_IDLE : ST_SHIFT;
         end
         ST_SHIFT: begin
            w_busy = 1'b1;
            w_oe   = 1'b1;
            if (w_cs_rise)             w_state_next = ST_IDLE;
            else if (r_cnt == 7'd64)   w_state_next = ST_DONE;
         end
         ST_DONE: begin
            w_busy = 1'b1;
            w_oe   = 1'b1;
            w_sent = 1'b1;
            w_state_next = ST_HOLD;
         end
         ST_HOLD: begin
            w_oe = 1'b1;
            // Level test: a CS release that landed during DONE is not lost.
            if (w_cs_s) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Frame is captured on the edge that enters LOAD so that bit 63 is ready
   // to be driven as soon as SHIFT begins.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shreg <= '0;
         r_cnt   <= '0;
         r_seq   <= '0;
         r_miso  <= 1'b0;
      end else begin
         if (w_state_next == ST_LOAD && r_state == ST_IDLE) begin
            r_shreg <= w_frame;
            r_cnt   <= '0;
         end else if (r_state == ST_SHIFT && w_state_next == ST_SHIFT) begin
            if (w_sclk_rise) begin
               r_cnt <= r_cnt + 7'd1;
            end
            // No shift before the first rise: the host samples bit 63 first.
            if (w_sclk_fall && r_cnt != 7'd0 && r_cnt != 7'd64) begin
               r_shreg <= {r_shreg[62:0], 1'b0};
            end
         end

         if (w_state_next == ST_DONE) begin
            r_seq <= r_seq + 4'd1;
         end

         // MISO is registered, so it follows the shift register one clock
         // later; outside SHIFT it is held low.
         r_miso <= (w_state_next == ST_SHIFT) ? r_shreg[63] : 1'b0;
      end
   end

   assign spi.o_miso   = r_miso;
   assign spi.o_misoOe = w_oe;
   assign o_busy       = w_busy;
   assign o_frameSent  = w_sent;
   assign o_seq        = r_seq;

endmodule

// File: tb/tb_status_tx.sv
// ---------------------------------------------------------------------------
// tb_status_tx
// Host-side SPI driver for status_tx. Each frame is clocked out with a slow
// SCLK (16 system clocks per period) and the received bits are compared with
// a frame built independently from the field layout and checksum rule.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_status_tx;

   logic        clk;
   logic        rst_n;
   logic [7:0]  i_flags;
   logic [11:0] i_vcIndex;
   logic [11:0] i_vcRepeat;
   logic [11:0] i_adc;
   logic        o_busy;
   logic        o_frameSent;
   logic [3:0]  o_seq;

   status_tx_if bus();

   status_tx #(.MSG_TYPE(8'h81), .SYNC_STAGES(2)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .spi         (bus.slave),
      .i_flags     (i_flags),
      .i_vcIndex   (i_vcIndex),
      .i_vcRepeat  (i_vcRepeat),
      .i_adc       (i_adc),
      .o_busy      (o_busy),
      .o_frameSent (o_frameSent),
      .o_seq       (o_seq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int fs_count = 0;
   int model_seq = 0;

   // frameSent is counted in clock cycles high, so a stretched pulse shows.
   always @(negedge clk) begin
      if (o_frameSent === 1'b1) fs_count++;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference frame: fields packed by position, checksum = XOR of every
   // byte except the checksum byte itself.
   function automatic logic [63:0] model_frame(input logic [7:0] f, input int s,
                                               input logic [11:0] vi, input logic [11:0] vr,
                                               input logic [11:0] a);
      logic [63:0] fr;
      logic [7:0]  cs;
      logic [3:0]  s4;
      s4 = s[3:0];
      fr = {f, s4, vi, vr, a, 8'h00, 8'h81};
      cs = 8'h00;
      for (int b = 0; b < 8; b++) begin
         if (b != 1) cs = cs ^ fr[b*8 +: 8];
      end
      fr[15:8] = cs;
      return fr;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      bus.i_sclk = 1'b0;
      bus.i_cs_n = 1'b1;
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(4);
      model_seq = 0;
   endtask

   task automatic set_random_inputs();
      i_flags    = 8'($urandom);
      i_vcIndex  = 12'($urandom);
      i_vcRepeat = 12'($urandom);
      i_adc      = 12'($urandom);
   endtask

   // Clocks nbits SCLK cycles. chg_at: bit index at which i_adc is forced to
   // 12'hFFF; rst_at: bit index at which reset is asserted (frame ends there).
   task automatic run_frame(input int nbits, input int chg_at, input int rst_at,
                            output logic [63:0] rx, output bit was_reset);
      rx = '0;
      was_reset = 1'b0;
      bus.i_cs_n = 1'b0;
      wait_clks(3);
      total++;
      if (bus.o_misoOe !== 1'b0) begin
         bad++;
         $display("FAIL oe_early: got %b want 0 three clocks after CS fall", bus.o_misoOe);
      end
      wait_clks(1);
      total++;
      if (bus.o_misoOe !== 1'b1 || o_busy !== 1'b1) begin
         bad++;
         $display("FAIL oe_rise: got oe=%b busy=%b want 1/1 four clocks after CS fall",
                  bus.o_misoOe, o_busy);
      end
      wait_clks(4);
      for (int i = 0; i < nbits; i++) begin
         if (i == chg_at) i_adc = 12'hFFF;
         if (i == rst_at) begin
            rst_n = 1'b0;
            #1;
            total++;
            if ({bus.o_miso, bus.o_misoOe, o_busy, o_frameSent, o_seq} !== 8'h00) begin
               bad++;
               $display("FAIL reset_mid: got miso=%b oe=%b busy=%b sent=%b seq=%h want all 0",
                        bus.o_miso, bus.o_misoOe, o_busy, o_frameSent, o_seq);
            end
            bus.i_sclk = 1'b0;
            bus.i_cs_n = 1'b1;
            wait_clks(3);
            rst_n = 1'b1;
            wait_clks(4);
            model_seq = 0;
            was_reset = 1'b1;
            return;
         end
         rx = {rx[62:0], bus.o_miso};
         bus.i_sclk = 1'b1;
         wait_clks(8);
         bus.i_sclk = 1'b0;
         wait_clks(8);
      end
      if (nbits == 64) begin
         total++;
         if (bus.o_miso !== 1'b0 || bus.o_misoOe !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL hold: got miso=%b oe=%b busy=%b want 0/1/0",
                     bus.o_miso, bus.o_misoOe, o_busy);
         end
      end
      bus.i_cs_n = 1'b1;
      wait_clks(8);
   endtask

   // Full frame with the current inputs, checked against the model.
   task automatic full_frame_check(input string name, output logic [63:0] rx);
      logic [63:0] exp;
      int          fs0;
      bit          r;
      exp = model_frame(i_flags, model_seq, i_vcIndex, i_vcRepeat, i_adc);
      fs0 = fs_count;
      run_frame(64, -1, -1, rx, r);
      model_seq = (model_seq + 1) % 16;
      total++;
      if (rx !== exp || fs_count - fs0 != 1 || o_seq !== 4'(model_seq)) begin
         bad++;
         $display("FAIL %s: got frame=%h pulses=%0d seq=%h want frame=%h pulses=1 seq=%h",
                  name, rx, fs_count - fs0, o_seq, exp, 4'(model_seq));
      end
      $display("frame %s: rx=%h seq=%h", name, rx, o_seq);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.i_sclk = 1'b0;
      bus.i_cs_n = 1'b1;
      i_flags = '0; i_vcIndex = '0; i_vcRepeat = '0; i_adc = '0;
      wait_clks(3);
      total++;
      if ({bus.o_miso, bus.o_misoOe, o_busy, o_frameSent, o_seq} !== 8'h00) begin
         bad++;
         $display("FAIL reset: got miso=%b oe=%b busy=%b sent=%b seq=%h want all 0",
                  bus.o_miso, bus.o_misoOe, o_busy, o_frameSent, o_seq);
      end
      rst_n = 1'b1;
      wait_clks(4);
      model_seq = 0;
      $display("reset: outputs idle");
   endtask

   task automatic test_frame_content();
      logic [63:0] rx;
      i_flags = 8'hA5; i_vcIndex = 12'h123; i_vcRepeat = 12'h456; i_adc = 12'h789;
      full_frame_check("content", rx);
      total++;
      if (rx !== 64'hA5012345_6789AD81) begin
         bad++;
         $display("FAIL content_const: got %h want a5012345_6789ad81", rx);
      end
   endtask

   task automatic test_all_zero();
      logic [63:0] rx;
      do_reset();
      i_flags = '0; i_vcIndex = '0; i_vcRepeat = '0; i_adc = '0;
      full_frame_check("zero", rx);
      total++;
      if (rx !== 64'h0000000000008181) begin
         bad++;
         $display("FAIL zero_const: got %h want 0000000000008181", rx);
      end
   endtask

   task automatic test_random_frames();
      logic [63:0] rx;
      for (int k = 0; k < 4; k++) begin
         set_random_inputs();
         full_frame_check("random", rx);
      end
   endtask

   task automatic test_abort();
      logic [63:0] rx;
      logic [63:0] exp;
      int          fs0;
      logic [3:0]  seq0;
      bit          r;
      set_random_inputs();
      exp  = model_frame(i_flags, model_seq, i_vcIndex, i_vcRepeat, i_adc);
      fs0  = fs_count;
      seq0 = o_seq;
      run_frame(20, -1, -1, rx, r);
      total++;
      if (rx[19:0] !== exp[63:44] || fs_count != fs0 || o_seq !== seq0 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL abort: got bits=%h pulses=%0d seq=%h busy=%b want bits=%h pulses=0 seq=%h busy=0",
                  rx[19:0], fs_count - fs0, o_seq, o_busy, exp[63:44], seq0);
      end
      $display("abort: partial=%h seq=%h", rx[19:0], o_seq);
      full_frame_check("after_abort", rx);
   endtask

   task automatic test_input_change();
      logic [63:0] rx;
      logic [63:0] exp;
      int          fs0;
      bit          r;
      i_flags = 8'h3C; i_vcIndex = 12'hABC; i_vcRepeat = 12'h0F0; i_adc = 12'h789;
      exp = model_frame(i_flags, model_seq, i_vcIndex, i_vcRepeat, 12'h789);
      fs0 = fs_count;
      run_frame(64, 40, -1, rx, r);
      model_seq = (model_seq + 1) % 16;
      total++;
      if (rx !== exp || rx[27:16] !== 12'h789 || fs_count - fs0 != 1) begin
         bad++;
         $display("FAIL input_change: got %h pulses=%0d want %h pulses=1", rx, fs_count - fs0, exp);
      end
      $display("input_change: rx=%h adc_field=%h", rx, rx[27:16]);
   endtask

   task automatic test_seq_wrap();
      logic [63:0] rx;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         set_random_inputs();
         full_frame_check("wrap", rx);
      end
      total++;
      if (rx[55:52] !== 4'hF || o_seq !== 4'h0) begin
         bad++;
         $display("FAIL seq_wrap: got field=%h o_seq=%h want field=f o_seq=0", rx[55:52], o_seq);
      end
   endtask

   task automatic test_reset_midframe();
      logic [63:0] rx;
      bit          r;
      set_random_inputs();
      run_frame(64, -1, 30, rx, r);
      total++;
      if (r !== 1'b1) begin
         bad++;
         $display("FAIL reset_path: got %b want 1", r);
      end
      i_flags = 8'hA5; i_vcIndex = 12'h123; i_vcRepeat = 12'h456; i_adc = 12'h789;
      full_frame_check("after_reset", rx);
      total++;
      if (rx !== 64'hA5012345_6789AD81) begin
         bad++;
         $display("FAIL after_reset_const: got %h want a5012345_6789ad81", rx);
      end
   endtask

   initial begin
      test_reset();
      test_frame_content();
      test_all_zero();
      test_random_frames();
      test_abort();
      test_input_change();
      test_seq_wrap();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
